bw_search_ctrl: RTL and testbench

BW_SEARCH_CTRL -- requirements
Module: bw_search_ctrl

---
 rtl/bw_search_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_bw_search_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bw_search_ctrl.sv
// bw_search_ctrl
//   Sequences a shared edge-finder engine over one accumulator frame.
//   It searches the left edge, then the right edge, captures both brackets
//   and reports a coarse bandwidth of right_f1 - left_f2.
//
// Ports
//   clk_i, rst_i           clock; synchronous active-high reset
//   frame_valid_i          new-frame pulse (accepted only while idle)
//   frame_ready_o          high while idle
//   eng_start_o/eng_sel_o  engine start pulse and direction (0 left, 1 right)
//   eng_busy_i             engine busy (informational only)
//   eng_valid_i, eng_*_i   engine result strobe and bracket bins/levels
//   left_*_o, right_*_o    captured brackets
//   bw_coarse_o            right_f1 - left_f2, one bit wider, signed
//   result_valid_o         one-cycle pulse when a full search completes
//   busy_o                 high whenever not idle
//   timeout_o              sticky engine-timeout flag
//   overrun_cnt_o          saturating count of frames dropped while busy
module bw_search_ctrl #(
  parameter int FREQ_BIN_WIDTH = 16,
  parameter int ACCUM_WIDTH    = 18,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             frame_valid_i,
  output logic                             frame_ready_o,
  output logic                             eng_start_o,
  output logic                             eng_sel_o,
  input  logic                             eng_busy_i,
  input  logic                             eng_valid_i,
  input  logic signed [FREQ_BIN_WIDTH-1:0] eng_f1_i,
  input  logic signed [FREQ_BIN_WIDTH-1:0] eng_f2_i,
  input  logic signed [ACCUM_WIDTH-1:0]    eng_L1_i,
  input  logic signed [ACCUM_WIDTH-1:0]    eng_L2_i,
  output logic signed [FREQ_BIN_WIDTH-1:0] left_f1_o,
  output logic signed [FREQ_BIN_WIDTH-1:0] left_f2_o,
  output logic signed [FREQ_BIN_WIDTH-1:0] right_f1_o,
  output logic signed [FREQ_BIN_WIDTH-1:0] right_f2_o,
  output logic signed [ACCUM_WIDTH-1:0]    left_L1_o,
  output logic signed [ACCUM_WIDTH-1:0]    left_L2_o,
  output logic signed [ACCUM_WIDTH-1:0]    right_L1_o,
  output logic signed [ACCUM_WIDTH-1:0]    right_L2_o,
  output logic signed [FREQ_BIN_WIDTH:0]   bw_coarse_o,
  output logic                             result_valid_o,
  output logic                             busy_o,
  output logic                             timeout_o,
  output logic [7:0]                       overrun_cnt_o
);

  // Counter only needs to reach TIMEOUT_CYCLES-1: the timeout fires in the
  // last allowed wait cycle instead of one cycle after it.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_L,
    WAIT_L,
    START_R,
    WAIT_R,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic signed [FREQ_BIN_WIDTH-1:0] left_f1_q, left_f1_d;
  logic signed [FREQ_BIN_WIDTH-1:0] left_f2_q, left_f2_d;
  logic signed [FREQ_BIN_WIDTH-1:0] right_f1_q, right_f1_d;
  logic signed [FREQ_BIN_WIDTH-1:0] right_f2_q, right_f2_d;
  logic signed [ACCUM_WIDTH-1:0]    left_l1_q, left_l1_d;
  logic signed [ACCUM_WIDTH-1:0]    left_l2_q, left_l2_d;
  logic signed [ACCUM_WIDTH-1:0]    right_l1_q, right_l1_d;
  logic signed [ACCUM_WIDTH-1:0]    right_l2_q, right_l2_d;
  logic signed [FREQ_BIN_WIDTH:0]   bw_coarse_q, bw_coarse_d;
  logic                             timeout_q, timeout_d;
  logic [7:0]                       overrun_q, overrun_d;

  logic unused_eng_busy;

  always_comb begin
    unused_eng_busy = eng_busy_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      left_f1_q   <= '0;
      left_f2_q   <= '0;
      right_f1_q  <= '0;
      right_f2_q  <= '0;
      left_l1_q   <= '0;
      left_l2_q   <= '0;
      right_l1_q  <= '0;
      right_l2_q  <= '0;
      bw_coarse_q <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_f1_q   <= left_f1_d;
      left_f2_q   <= left_f2_d;
      right_f1_q  <= right_f1_d;
      right_f2_q  <= right_f2_d;
      left_l1_q   <= left_l1_d;
      left_l2_q   <= left_l2_d;
      right_l1_q  <= right_l1_d;
      right_l2_q  <= right_l2_d;
      bw_coarse_q <= bw_coarse_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    left_f1_d   = left_f1_q;
    left_f2_d   = left_f2_q;
    right_f1_d  = right_f1_q;
    right_f2_d  = right_f2_q;
    left_l1_d   = left_l1_q;
    left_l2_d   = left_l2_q;
    right_l1_d  = right_l1_q;
    right_l2_d  = right_l2_q;
    bw_coarse_d = bw_coarse_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (frame_valid_i) begin
          state_d = START_L;
        end
      end
      START_L: begin
        cnt_d   = '0;
        state_d = WAIT_L;
      end
      WAIT_L: begin
        if (eng_valid_i) begin
          left_f1_d = eng_f1_i;
          left_f2_d = eng_f2_i;
          left_l1_d = eng_L1_i;
          left_l2_d = eng_L2_i;
          state_d   = START_R;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      START_R: begin
        cnt_d   = '0;
        state_d = WAIT_R;
      end
      WAIT_R: begin
        if (eng_valid_i) begin
          right_f1_d = eng_f1_i;
          right_f2_d = eng_f2_i;
          right_l1_d = eng_L1_i;
          right_l2_d = eng_L2_i;
          // Difference is formed at capture so it is registered and valid
          // in the same cycle as result_valid_o.
          bw_coarse_d = {eng_f1_i[FREQ_BIN_WIDTH-1], eng_f1_i}
                      - {left_f2_q[FREQ_BIN_WIDTH-1], left_f2_q};
          state_d    = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_valid_i && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_comb begin
    frame_ready_o  = (state_q == IDLE);
    busy_o         = (state_q != IDLE);
    eng_start_o    = (state_q == START_L) || (state_q == START_R);
    eng_sel_o      = (state_q == START_R) || (state_q == WAIT_R);
    result_valid_o = (state_q == DONE);
  end

  assign left_f1_o     = left_f1_q;
  assign left_f2_o     = left_f2_q;
  assign right_f1_o    = right_f1_q;
  assign right_f2_o    = right_f2_q;
  assign left_L1_o     = left_l1_q;
  assign left_L2_o     = left_l2_q;
  assign right_L1_o    = right_l1_q;
  assign right_L2_o    = right_l2_q;
  assign bw_coarse_o   = bw_coarse_q;
  assign timeout_o     = timeout_q;
  assign overrun_cnt_o = overrun_q;

endmodule

// File: tb/tb_bw_search_ctrl.sv
module tb_bw_search_ctrl;

  localparam int FW = 16;
  localparam int AW = 18;
  localparam int TO = 64;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 frame_valid_i;
  logic                 frame_ready_o;
  logic                 eng_start_o;
  logic                 eng_sel_o;
  logic                 eng_busy_i;
  logic                 eng_valid_i;
  logic signed [FW-1:0] eng_f1_i, eng_f2_i;
  logic signed [AW-1:0] eng_L1_i, eng_L2_i;
  logic signed [FW-1:0] left_f1_o, left_f2_o, right_f1_o, right_f2_o;
  logic signed [AW-1:0] left_L1_o, left_L2_o, right_L1_o, right_L2_o;
  logic signed [FW:0]   bw_coarse_o;
  logic                 result_valid_o;
  logic                 busy_o;
  logic                 timeout_o;
  logic [7:0]           overrun_cnt_o;

  bw_search_ctrl #(
    .FREQ_BIN_WIDTH(FW),
    .ACCUM_WIDTH   (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .frame_valid_i (frame_valid_i),
    .frame_ready_o (frame_ready_o),
    .eng_start_o   (eng_start_o),
    .eng_sel_o     (eng_sel_o),
    .eng_busy_i    (eng_busy_i),
    .eng_valid_i   (eng_valid_i),
    .eng_f1_i      (eng_f1_i),
    .eng_f2_i      (eng_f2_i),
    .eng_L1_i      (eng_L1_i),
    .eng_L2_i      (eng_L2_i),
    .left_f1_o     (left_f1_o),
    .left_f2_o     (left_f2_o),
    .right_f1_o    (right_f1_o),
    .right_f2_o    (right_f2_o),
    .left_L1_o     (left_L1_o),
    .left_L2_o     (left_L2_o),
    .right_L1_o    (right_L1_o),
    .right_L2_o    (right_L2_o),
    .bw_coarse_o   (bw_coarse_o),
    .result_valid_o(result_valid_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o),
    .overrun_cnt_o (overrun_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lf1, lf2, ll1, ll2;
    int rf1, rf2, rl1, rl2;
    int bw;
  } res_t;

  // Reference model: what the visible registers must hold right now.
  res_t m;
  int   m_ovr;
  bit   m_to;
  res_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding frame.
  res_t mon_e;
  always @(negedge clk) begin
    if (result_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_left_f1",  int'(left_f1_o),   mon_e.lf1);
        chk("res_left_f2",  int'(left_f2_o),   mon_e.lf2);
        chk("res_left_L1",  int'(left_L1_o),   mon_e.ll1);
        chk("res_left_L2",  int'(left_L2_o),   mon_e.ll2);
        chk("res_right_f1", int'(right_f1_o),  mon_e.rf1);
        chk("res_right_f2", int'(right_f2_o),  mon_e.rf2);
        chk("res_right_L1", int'(right_L1_o),  mon_e.rl1);
        chk("res_right_L2", int'(right_L2_o),  mon_e.rl2);
        chk("res_bw",       int'(bw_coarse_o), mon_e.bw);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic garbage();
    eng_f1_i   = FW'($urandom);
    eng_f2_i   = FW'($urandom);
    eng_L1_i   = AW'($urandom);
    eng_L2_i   = AW'($urandom);
    eng_busy_i = 1'($urandom);
  endtask

  task automatic flood(input bit en);
    frame_valid_i = en;
    if (en && m_ovr < 255) m_ovr++;
  endtask

  task automatic drive_eng(input int f1, input int f2, input int l1, input int l2);
    eng_valid_i = 1'b1;
    eng_f1_i    = FW'(f1);
    eng_f2_i    = FW'(f2);
    eng_L1_i    = AW'(l1);
    eng_L2_i    = AW'(l2);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_left_f1"},  int'(left_f1_o),     m.lf1);
    chk({tag, "_left_f2"},  int'(left_f2_o),     m.lf2);
    chk({tag, "_left_L1"},  int'(left_L1_o),     m.ll1);
    chk({tag, "_left_L2"},  int'(left_L2_o),     m.ll2);
    chk({tag, "_right_f1"}, int'(right_f1_o),    m.rf1);
    chk({tag, "_right_f2"}, int'(right_f2_o),    m.rf2);
    chk({tag, "_right_L1"}, int'(right_L1_o),    m.rl1);
    chk({tag, "_right_L2"}, int'(right_L2_o),    m.rl2);
    chk({tag, "_bw"},       int'(bw_coarse_o),   m.bw);
    chk({tag, "_overrun"},  int'(overrun_cnt_o), m_ovr);
    chk({tag, "_timeout"},  int'(timeout_o),     int'(m_to));
  endtask

  task automatic check_ctrl_idle(input string tag);
    chk({tag, "_frame_ready"},  int'(frame_ready_o),  1);
    chk({tag, "_busy"},         int'(busy_o),         0);
    chk({tag, "_eng_start"},    int'(eng_start_o),    0);
    chk({tag, "_eng_sel"},      int'(eng_sel_o),      0);
    chk({tag, "_result_valid"}, int'(result_valid_o), 0);
  endtask

  task automatic model_reset();
    m     = '{default: 0};
    m_ovr = 0;
    m_to  = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_i = 1'b1; frame_valid_i = 1'b0; eng_valid_i = 1'b0; garbage();
    step();
    model_reset();
    check_ctrl_idle("reset");
    check_regs("reset");
    rst_i = 1'b0;
  endtask

  // mode 0: normal, 1: left never answers, 2: right never answers,
  // 3: reset asserted during WAIT_R.  Delays are cycles after the start pulse.
  task automatic run_frame(input res_t v, input int dl, input int dr, input int mode,
                           input bit fl, input bit poke_done);
    res_t e;
    int   k;
    e    = v;
    e.bw = v.rf1 - v.lf2;
    if (mode == 0) exp_q.push_back(e);

    step();
    chk("frame_ready_before", int'(frame_ready_o), 1);
    frame_valid_i = 1'b1; eng_valid_i = 1'b0; garbage();
    step();
    frame_valid_i = 1'b0; garbage(); eng_valid_i = 1'($urandom);
    chk("start_l_pulse", int'(eng_start_o), 1);
    chk("start_l_sel",   int'(eng_sel_o),   0);
    chk("start_l_busy",  int'(busy_o),      1);
    chk("start_l_ready", int'(frame_ready_o), 0);

    if (mode == 1) begin
      for (int i = 1; i <= TO; i++) begin
        step(); garbage(); eng_valid_i = 1'b0; flood(fl);
        if (i == 1) chk("wait_l_start_low", int'(eng_start_o), 0);
        if (i == TO) chk("timeout_not_early", int'(timeout_o), int'(m_to));
      end
      step(); frame_valid_i = 1'b0;
      m_to = 1'b1;
      check_ctrl_idle("timeout_l");
      check_regs("timeout_l");
      return;
    end

    for (int i = 1; i <= dl; i++) begin
      step(); garbage(); flood(fl); eng_valid_i = 1'b0;
      if (i == 1) begin
        chk("wait_l_start_low", int'(eng_start_o), 0);
        chk("wait_l_sel",       int'(eng_sel_o),   0);
      end
      if (i == dl) drive_eng(v.lf1, v.lf2, v.ll1, v.ll2);
    end
    m.lf1 = v.lf1; m.lf2 = v.lf2; m.ll1 = v.ll1; m.ll2 = v.ll2;

    step();
    frame_valid_i = 1'b0; garbage(); eng_valid_i = 1'($urandom);
    chk("start_r_pulse", int'(eng_start_o), 1);
    chk("start_r_sel",   int'(eng_sel_o),   1);

    if (mode == 2) begin
      for (int i = 1; i <= TO; i++) begin
        step(); garbage(); eng_valid_i = 1'b0; flood(fl);
        if (i == 1) chk("wait_r_sel", int'(eng_sel_o), 1);
        if (i == TO) chk("timeout_not_early", int'(timeout_o), int'(m_to));
      end
      step(); frame_valid_i = 1'b0;
      m_to = 1'b1;
      check_ctrl_idle("timeout_r");
      check_regs("timeout_r");
      return;
    end

    if (mode == 3) begin
      k = $urandom_range(1, 60);
      for (int i = 1; i <= k; i++) begin
        step(); garbage(); eng_valid_i = 1'b0;
        if (i == k) begin
          chk("wait_r_busy_pre_reset", int'(busy_o), 1);
          frame_valid_i = 1'b0;
          rst_i = 1'b1;
        end else begin
          flood(fl);
        end
      end
      step();
      model_reset();
      check_ctrl_idle("reset_wait_r");
      check_regs("reset_wait_r");
      rst_i = 1'b0; eng_valid_i = 1'b0;
      return;
    end

    for (int i = 1; i <= dr; i++) begin
      step(); garbage(); flood(fl); eng_valid_i = 1'b0;
      if (i == 1) begin
        chk("wait_r_start_low", int'(eng_start_o), 0);
        chk("wait_r_sel",       int'(eng_sel_o),   1);
      end
      if (i == dr) drive_eng(v.rf1, v.rf2, v.rl1, v.rl2);
    end
    m.rf1 = v.rf1; m.rf2 = v.rf2; m.rl1 = v.rl1; m.rl2 = v.rl2; m.bw = e.bw;

    step();
    chk("done_result_valid", int'(result_valid_o), 1);
    chk("done_busy",         int'(busy_o),         1);
    chk("done_sel",          int'(eng_sel_o),      0);
    garbage(); eng_valid_i = 1'($urandom);
    frame_valid_i = 1'b0;
    if (poke_done) flood(1'b1);

    step();
    frame_valid_i = 1'b0; eng_valid_i = 1'b0;
    check_ctrl_idle("after_done");
    check_regs("after_done");
  endtask

  function automatic res_t mk(input int lf1, input int lf2, input int rf1, input int rf2);
    res_t r;
    r = '{default: 0};
    r.lf1 = lf1; r.lf2 = lf2; r.rf1 = rf1; r.rf2 = rf2;
    r.ll1 = 1000; r.ll2 = -2000; r.rl1 = 131071; r.rl2 = -131072;
    return r;
  endfunction

  function automatic res_t rnd();
    res_t r;
    r.lf1 = int'($signed(FW'($urandom)));
    r.lf2 = int'($signed(FW'($urandom)));
    r.rf1 = int'($signed(FW'($urandom)));
    r.rf2 = int'($signed(FW'($urandom)));
    r.ll1 = int'($signed(AW'($urandom)));
    r.ll2 = int'($signed(AW'($urandom)));
    r.rl1 = int'($signed(AW'($urandom)));
    r.rl2 = int'($signed(AW'($urandom)));
    r.bw  = 0;
    return r;
  endfunction

  initial begin
    int mode;
    int gap;
    rst_i = 1'b1; frame_valid_i = 1'b0; eng_valid_i = 1'b0; garbage();
    model_reset();
    step(); step();
    check_ctrl_idle("por");
    check_regs("por");
    rst_i = 1'b0;

    // Nominal and signed-boundary brackets.
    run_frame(mk(10, 11, 30, 31), 5, 5, 0, 1'b0, 1'b0);
    chk("nominal_bw", int'(bw_coarse_o), 19);
    run_frame(mk(-150, -100, -20, -5), 5, 5, 0, 1'b0, 1'b0);
    chk("neg_bw", int'(bw_coarse_o), 80);
    run_frame(mk(0, 32767, -32768, 0), 3, 7, 0, 1'b0, 1'b0);
    chk("extreme_bw", int'(bw_coarse_o), -65535);

    // Left timeout, then a nominal frame with the flag still set.
    run_frame(mk(1, 2, 3, 4), 1, 1, 1, 1'b0, 1'b0);
    run_frame(mk(10, 11, 30, 31), 5, 5, 0, 1'b0, 1'b0);
    chk("timeout_sticky", int'(timeout_o), 1);

    // Valid in the last allowed cycle on both sides.
    do_reset();
    run_frame(mk(7, 8, 40, 41), TO, TO, 0, 1'b0, 1'b0);
    chk("race_no_timeout", int'(timeout_o), 0);

    // Overrun flood across several searches.
    for (int i = 0; i < 3; i++) run_frame(rnd(), 60, 60, 0, 1'b1, 1'b1);
    chk("overrun_saturated", int'(overrun_cnt_o), 255);

    run_frame(rnd(), 9, 1, 2, 1'b0, 1'b0);
    run_frame(rnd(), 4, 30, 3, 1'b1, 1'b0);

    // Randomised frames with idle gaps carrying ignored engine strobes.
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step(); garbage(); eng_valid_i = 1'($urandom); frame_valid_i = 1'b0;
      end
      mode = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
      run_frame(rnd(), $urandom_range(1, TO), $urandom_range(1, TO), mode,
                ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    step(); step();
    chk("pending_results", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
